// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
// Shared datapath types for the pipelined MIPS core.
//   word_t      : 32-bit data word
//   regbits_t   : 5-bit register index
//   mem_state_t : EX/MEM stage sequencer states
//   ex_mem_t    : fields held in the EX/MEM pipeline register
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACCESS = 2'd1,
        READY  = 2'd2,
        HALTED = 2'd3
    } mem_state_t;

    typedef struct packed {
        logic     valid;
        word_t    alu_out;
        word_t    store_data;
        regbits_t wsel;
        logic     regwen;
        logic     memren;
        logic     memwen;
        logic     halt;
    } ex_mem_t;

    // A bubble carries nothing: all fields cleared so no stale destination
    // or request flags can leak out of an empty slot.
    localparam ex_mem_t EX_MEM_BUBBLE = '0;

endpackage

// File: rtl/ex_mem_latch_if.sv
// ex_mem_latch_if
// Bundle of the EX/MEM latch signals.
//   em modport : the latch side (EX inputs, dcache response in; request,
//                forwarding and MEM/WB results out)
//   tb modport : the driving side (mirror of em)
// reg_wr_mem is routed straight to the forwarding unit's interface.
interface ex_mem_latch_if
    import cpu_types_pkg::*;
();
    logic     ex_valid;
    word_t    ex_alu_out;
    word_t    ex_store_data;
    regbits_t ex_wsel;
    logic     ex_regwen;
    logic     ex_memren;
    logic     ex_memwen;
    logic     ex_halt;
    logic     advance;
    logic     flush;
    logic     dhit;
    word_t    dmemload;
    logic     dmemREN;
    logic     dmemWEN;
    word_t    dmemaddr;
    word_t    dmemstore;
    logic     mem_busy;
    regbits_t reg_wr_mem;
    word_t    mem_fwd_data;
    logic     mem_valid;
    regbits_t mem_wsel;
    logic     mem_regwen;
    word_t    mem_wdat;
    logic     mem_halt;
    logic     halted;

    modport em (
        input  ex_valid, ex_alu_out, ex_store_data, ex_wsel, ex_regwen,
               ex_memren, ex_memwen, ex_halt, advance, flush, dhit, dmemload,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_busy, reg_wr_mem,
               mem_fwd_data, mem_valid, mem_wsel, mem_regwen, mem_wdat,
               mem_halt, halted
    );

    modport tb (
        output ex_valid, ex_alu_out, ex_store_data, ex_wsel, ex_regwen,
               ex_memren, ex_memwen, ex_halt, advance, flush, dhit, dmemload,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_busy, reg_wr_mem,
               mem_fwd_data, mem_valid, mem_wsel, mem_regwen, mem_wdat,
               mem_halt, halted
    );

endinterface

// File: rtl/ex_mem_latch.sv
// ex_mem_latch
// EX/MEM pipeline register plus MEM-stage data-access sequencer.
// Captures the EX result, drives the data-memory request until dhit, then
// holds the completed result for the MEM/WB latch.
// Ports:
//   CLK, RST (async, active-high)
//   ex_*            : EX-stage entry to capture
//   advance, flush  : hazard-unit latch enable / bubble insert
//   dhit, dmemload  : dcache completion and load data
//   dmemREN/WEN, dmemaddr, dmemstore : data request
//   mem_busy        : access outstanding, upstream must stall
//   reg_wr_mem, mem_fwd_data : forwarding source
//   mem_valid, mem_wsel, mem_regwen, mem_wdat, mem_halt : MEM/WB result
//   halted          : sticky halt
module ex_mem_latch
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_wsel,
    input  logic        ex_regwen,
    input  logic        ex_memren,
    input  logic        ex_memwen,
    input  logic        ex_halt,
    input  logic        advance,
    input  logic        flush,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic        mem_busy,
    output logic [4:0]  reg_wr_mem,
    output logic [31:0] mem_fwd_data,
    output logic        mem_valid,
    output logic [4:0]  mem_wsel,
    output logic        mem_regwen,
    output logic [31:0] mem_wdat,
    output logic        mem_halt,
    output logic        halted
);

    mem_state_t state_q;
    ex_mem_t    entry_q;
    word_t      load_data_q;

    // Single sequential FSM. EMPTY and READY both accept a new entry; ACCESS
    // ignores advance (mem_busy is high) and HALTED only leaves through RST.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= EMPTY;
            entry_q     <= EX_MEM_BUBBLE;
            load_data_q <= '0;
        end else begin
            case (state_q)
                ACCESS: begin
                    // A store completes the same way, it just has no data.
                    if (dhit) begin
                        if (entry_q.memren) begin
                            load_data_q <= dmemload;
                        end
                        state_q <= READY;
                    end
                end
                HALTED: begin
                    state_q <= HALTED;
                end
                default: begin
                    if (advance) begin
                        if (flush || !ex_valid) begin
                            entry_q <= EX_MEM_BUBBLE;
                            state_q <= EMPTY;
                        end else begin
                            entry_q.valid      <= 1'b1;
                            entry_q.alu_out    <= ex_alu_out;
                            entry_q.store_data <= ex_store_data;
                            entry_q.wsel       <= ex_wsel;
                            entry_q.regwen     <= ex_regwen;
                            entry_q.memren     <= ex_memren;
                            entry_q.memwen     <= ex_memwen;
                            entry_q.halt       <= ex_halt;
                            if (ex_halt) begin
                                state_q <= HALTED;
                            end else if (ex_memren || ex_memwen) begin
                                state_q <= ACCESS;
                            end else begin
                                state_q <= READY;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Request lines decode directly from the registered state so an
    // asynchronous reset drops them without waiting for a clock edge.
    assign mem_busy  = (state_q == ACCESS);
    assign dmemREN   = mem_busy && entry_q.memren;
    assign dmemWEN   = mem_busy && entry_q.memwen;
    assign dmemaddr  = entry_q.alu_out;
    assign dmemstore = entry_q.store_data;

    assign mem_valid  = (state_q == READY) || (state_q == HALTED);
    assign mem_wdat   = entry_q.memren ? load_data_q : entry_q.alu_out;
    assign mem_fwd_data = mem_wdat;
    assign mem_wsel   = entry_q.wsel;
    assign mem_regwen = entry_q.regwen;
    assign mem_halt   = (state_q == HALTED) && entry_q.halt;
    assign halted     = (state_q == HALTED);

    // Register 0 is hardwired; never offer it as a forwarding destination.
    assign reg_wr_mem = (entry_q.valid && entry_q.regwen && (entry_q.wsel != 5'd0))
                        ? entry_q.wsel : 5'd0;

endmodule
